branch_predictor: RTL

Direct-mapped branch target buffer with 2-bit saturating direction counters. It supplies the prediction inputs consumed by the fetch-stage PC unit: pred_control and pred_branch. Fetch looks up the current fetch address combinationally. The resolution stage (EX/MEM) writes back each branch outcome, and the block trains on it. Two performance counters track resolved branches and mispredictions.

---
 rtl/branch_predictor.sv | 101 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup for fetch; training and perf counters updated from resolution.
module branch_predictor #(
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_addr,
  output logic        pred_control,
  output logic [31:0] pred_branch,
  input  logic        update_en,
  input  logic [31:0] update_addr,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  input  logic        table_clear,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, upd_write;
  logic [1:0]       ctr_d;
  logic [31:0]      target_d;

  // Byte-offset bits of both addresses carry no information for word-aligned PCs.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{lookup_addr[1:0], update_addr[1:0]};

  assign lk_idx  = lookup_addr[IDX_W+1:2];
  assign lk_tag  = lookup_addr[31:IDX_W+2];
  assign upd_idx = update_addr[IDX_W+1:2];
  assign upd_tag = update_addr[31:IDX_W+2];

  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_control = lk_hit && ctr_q[lk_idx][1];
  assign pred_branch  = pred_control ? target_q[lk_idx] : 32'h0;

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A not-taken miss leaves the table alone; anything else rewrites the entry.
  assign upd_write = update_en && (upd_hit || update_taken);

  always_comb begin
    ctr_d    = 2'b10;
    target_d = target_q[upd_idx];
    if (update_taken) target_d = update_target;
    if (upd_hit) begin
      if (update_taken) ctr_d = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
      else              ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (table_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_write) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      ctr_q[upd_idx]    <= ctr_d;
      target_q[upd_idx] <= target_d;
    end
  end

  assign branch_count_d     = branch_count_q + {31'b0, update_en};
  assign mispredict_count_d = mispredict_count_q + {31'b0, update_en & update_mispredict};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
